regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and scoreboard for the RISC-V 32-bit core's three-ported register file. It shares the file's single write port (WE3/A3/WD3) between the ALU result path and the load unit using a fair valid/ready handshake. It also keeps a pending-write bit per architectural register, so the issue stage can stall on RAW/WAW hazards. It sits between the execute/memory stages and Register_File_DP and drives that block's write port directly.

## Interface
- XLEN, 32, data width of write-back values
- AW, 5, register address width (32 architectural registers)

- CLK  input  1  core clock; all state updates on rising edge
- RST  input  1  reset; asynchronous assert, active-low
- alu_valid  input  1  ALU result available
- alu_rd  input  AW  ALU destination register
- alu_data  input  XLEN  ALU result
- alu_ready  output  1  ALU result accepted this cycle
- mem_valid  input  1  load data available
- mem_rd  input  AW  load destination register
- mem_data  input  XLEN  load data
- mem_ready  output  1  load data accepted this cycle
- issue_valid  input  1  instruction issued this cycle with a destination register
- issue_rd  input  AW  destination of the issued instruction
- rs1, rs2  input  AW  source registers of the instruction in issue
- rs1_busy, rs2_busy, rd_busy  output  1  pending write on rs1 / rs2 / issue_rd
- WE3  output  1  register-file write enable
- A3  output  AW  register-file write address
- WD3  output  XLEN  register-file write data

## Operation
- **Handshake.** A transfer occurs when valid and ready are both high at a rising edge. A requester holds valid/rd/data stable until accepted. valid must not depend on ready.
- **Ready.** ready is combinational from the two valids and the `last` flag. At most one ready is high per cycle. ready is never high unless the matching valid is high.
- **Arbitration.**
  - If one requester is valid, it is granted.
  - If both are valid, grant the requester not granted last, using the `last` flag (0 = ALU, 1 = MEM).
  - `last` updates only on a transfer.
  - Neither requester waits more than one cycle behind the other.
- **Write stage.** The accepted rd/data are registered into A3/WD3. WE3 = 1 in the following cycle unless rd == 0. Writes to x0 complete the handshake but produce WE3 = 0 and no scoreboard effect.
- **Scoreboard.** pending[31:0].
  - Set: issue_valid && issue_rd != 0 sets pending[issue_rd].
  - Clear: WE3 at a rising edge clears pending[A3].
  - Same register set and cleared in one cycle: set wins (new producer).
  - pending[0] is always 0.
- **Hazard outputs.** Combinational: rsN_busy = pending[rsN], rd_busy = pending[issue_rd].
  - No forwarding: rsN_busy stays high through the cycle in which WE3 writes that register. It falls the cycle after.
  - The issue stage must not issue while any busy output it depends on is high. A bench assertion checks issue_valid && rd_busy never occurs.

## Timing
- **Reset values.** WE3 = 0, A3 = 0, WD3 = 0, pending = 0, last = 1 (ALU wins the first conflict). alu_ready/mem_ready follow their combinational rule. They are 0 while RST is low.
- **Accept-to-write latency.** Accept in cycle N; WE3/A3/WD3 valid in cycle N+1; Register_File_DP captures at the end of N+1.
- **Issue-to-busy.** Issue in cycle N → pending visible from cycle N+1.
- **Throughput.** One write-back per cycle. Back-to-back transfers are allowed. With no accept in a cycle, WE3 = 0 in the next cycle.
- **Reset mid-operation.** A registered write in flight is dropped (WE3 → 0 immediately). pending clears. Requesters re-present after reset.

## Structure
- Shared package `riscv_pkg`: XLEN, AW, NREG = 32, and the requester encoding (ALU = 0, MEM = 1).
- One natural sub-module: `wb_rr_arbiter`, a 2-way round-robin grant with the `last` flag. The scoreboard and write register stay in the top.
- Expected size: about 150–250 lines.

## Test plan
1. **Reset.** Hold RST low 3 cycles with alu_valid = 1 → WE3 = 0, all busy = 0, alu_ready = 0. Release → alu_ready = 1 next edge. WE3 = 1, A3 = alu_rd one cycle after accept.
2. **Single write.** Issue rd = 5, then ALU sends rd = 5, data = 0xDEADBEEF.
   - rs1 = 5 busy from the cycle after issue.
   - WE3 = 1, A3 = 5, WD3 = 0xDEADBEEF one cycle after accept.
   - rs1_busy = 0 the cycle after the write.
3. **Conflict fairness.** Both valid for 4 cycles (ALU rd = 1..4, MEM rd = 9..12) → grants alternate ALU, MEM, ALU, MEM after reset. No grant is lost and WE3 is high each cycle.
4. **x0 write.** MEM sends rd = 0, data = 0x1234 → mem_ready = 1, WE3 stays 0, pending unchanged.
5. **Set and clear collide.** Issue rd = 7 in the same cycle WE3 writes A3 = 7 → pending[7] remains 1 (rd_busy for 7 stays high).
6. **Reset mid-flight.** Accept ALU rd = 3 then assert RST → WE3 = 0 at once, pending[3] = 0 after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core package: datapath widths, register count and the
// write-back requester encoding used by the arbiter's `last` flag.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  // Requester encoding for the round-robin `last` flag.
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;
endpackage

// File: rtl/wb_rr_arbiter.sv
// 2-way round-robin grant between the ALU and load write-back paths.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   alu_valid, mem_valid  requests
//   alu_ready, mem_ready  grants (combinational, one-hot or zero)
module wb_rr_arbiter
  import riscv_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic alu_valid,
  input  logic mem_valid,
  output logic alu_ready,
  output logic mem_ready
);

  logic last;      // requester granted most recently
  logic grant_mem;

  // MEM wins if alone, or on a conflict when ALU was the last winner.
  assign grant_mem = mem_valid && (!alu_valid || last == REQ_ALU);

  // Readies are held low while reset is asserted.
  assign mem_ready = rst_n && grant_mem;
  assign alu_ready = rst_n && alu_valid && !grant_mem;

  // last resets to MEM so the ALU wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         last <= REQ_MEM;
    else if (alu_ready) last <= REQ_ALU;
    else if (mem_ready) last <= REQ_MEM;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and scoreboard in front of the register file's single
// write port. Arbitrates ALU vs load results, registers the winner onto
// WE3/A3/WD3, and keeps a pending-write bit per register for hazard stalls.
// Ports:
//   CLK, RST                         clock, async active-low reset
//   alu_valid/rd/data, alu_ready     ALU write-back handshake
//   mem_valid/rd/data, mem_ready     load write-back handshake
//   issue_valid, issue_rd            destination of the issuing instruction
//   rs1, rs2                         sources of the instruction in issue
//   rs1_busy, rs2_busy, rd_busy      pending-write flags
//   WE3, A3, WD3                     register-file write port
module regfile_wb_arbiter
  import riscv_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rd_busy,
  output logic            WE3,
  output logic [AW-1:0]   A3,
  output logic [XLEN-1:0] WD3
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] set_mask, clr_mask, pending_nxt;
  logic            accept;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;

  wb_rr_arbiter u_arb (
    .clk       (CLK),
    .rst_n     (RST),
    .alu_valid (alu_valid),
    .mem_valid (mem_valid),
    .alu_ready (alu_ready),
    .mem_ready (mem_ready)
  );

  assign accept   = alu_ready || mem_ready;
  assign sel_rd   = mem_ready ? mem_rd   : alu_rd;
  assign sel_data = mem_ready ? mem_data : alu_data;

  // Write stage: x0 writes complete the handshake but never assert WE3.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      WE3 <= 1'b0;
      A3  <= '0;
      WD3 <= '0;
    end else begin
      WE3 <= accept && (sel_rd != '0);
      if (accept) begin
        A3  <= sel_rd;
        WD3 <= sel_data;
      end
    end
  end

  // Set is applied after clear so a new producer wins over the retiring one.
  always_comb begin
    set_mask    = '0;
    clr_mask    = '0;
    if (issue_valid) set_mask = NREG'(1) << issue_rd;
    if (WE3)         clr_mask = NREG'(1) << A3;
    pending_nxt    = (pending & ~clr_mask) | set_mask;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) pending <= '0;
    else      pending <= pending_nxt;
  end

  // No forwarding: busy stays up through the write cycle itself.
  assign rs1_busy = pending[rs1];
  assign rs2_busy = pending[rs2];
  assign rd_busy  = pending[issue_rd];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  logic        CLK = 1'b0;
  logic        RST;
  logic        alu_valid, mem_valid, issue_valid;
  logic [4:0]  alu_rd, mem_rd, issue_rd, rs1, rs2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, rs1_busy, rs2_busy, rd_busy, WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;

  int n_cmp = 0;
  int n_fail = 0;

  regfile_wb_arbiter dut (
    .CLK(CLK), .RST(RST),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .WE3(WE3), .A3(A3), .WD3(WD3)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Rules: a lone requester is served; on a conflict the one not served last
  // is served. The served write appears on the port the next cycle (no write
  // for x0). A register is pending from the cycle after issue until the
  // cycle after it is written, with a new issue overriding the retirement.
  logic        m_alu_last;   // 1: ALU was served most recently
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  logic [31:0] m_pend;
  logic        e_alu, e_mem;

  always_comb begin
    e_alu = 1'b0;
    e_mem = 1'b0;
    if (RST) begin
      if (alu_valid && mem_valid) begin
        if (m_alu_last) e_mem = 1'b1;
        else            e_alu = 1'b1;
      end else begin
        e_alu = alu_valid;
        e_mem = mem_valid;
      end
    end
  end

  always @(posedge CLK or negedge RST) begin : model
    logic [31:0] np;
    if (!RST) begin
      m_alu_last <= 1'b0;
      m_we <= 1'b0; m_a3 <= '0; m_wd <= '0; m_pend <= '0;
    end else begin
      np = m_pend;
      if (m_we) np[m_a3] = 1'b0;
      if (issue_valid && issue_rd != 0) np[issue_rd] = 1'b1;
      m_pend <= np;
      m_we <= 1'b0;
      if (e_alu) begin
        m_we <= (alu_rd != 0); m_a3 <= alu_rd; m_wd <= alu_data; m_alu_last <= 1'b1;
      end else if (e_mem) begin
        m_we <= (mem_rd != 0); m_a3 <= mem_rd; m_wd <= mem_data; m_alu_last <= 1'b0;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge CLK) begin
    chk("alu_ready", 32'(alu_ready), 32'(e_alu));
    chk("mem_ready", 32'(mem_ready), 32'(e_mem));
    chk("WE3", 32'(WE3), 32'(m_we));
    chk("A3", 32'(A3), 32'(m_a3));
    chk("WD3", WD3, m_wd);
    chk("rs1_busy", 32'(rs1_busy), 32'(m_pend[rs1]));
    chk("rs2_busy", 32'(rs2_busy), 32'(m_pend[rs2]));
    chk("rd_busy", 32'(rd_busy), 32'(m_pend[issue_rd]));
    chk("issue_on_busy", 32'(issue_valid && rd_busy), 32'd0);
  end

  // Write-port log for the fairness test.
  logic log_en = 1'b0;
  logic [4:0] wlog[$];
  always @(negedge CLK) if (log_en && WE3) wlog.push_back(A3);

  task automatic cyc();    @(posedge CLK); #1; endtask
  task automatic at_neg(); @(negedge CLK); #1; endtask

  initial begin : stim
    int ai, mi, c;
    logic ga, gm;
    logic [4:0] exp_seq [8];
    exp_seq = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11, 5'd4, 5'd12};

    RST = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    issue_valid = 1'b0; issue_rd = '0; rs1 = 5'd2; rs2 = 5'd0;

    // 1. reset
    repeat (3) begin
      at_neg;
      chk("rst_we3", 32'(WE3), 0);
      chk("rst_alu_ready", 32'(alu_ready), 0);
      chk("rst_rs1_busy", 32'(rs1_busy), 0);
    end
    cyc(); RST = 1'b1;
    at_neg; chk("post_rst_alu_ready", 32'(alu_ready), 1);
    cyc(); alu_valid = 1'b0;
    at_neg; chk("first_we3", 32'(WE3), 1); chk("first_a3", 32'(A3), 2); chk("first_wd3", WD3, 32'h22);

    // 2. single write
    cyc(); issue_valid = 1'b1; issue_rd = 5'd5; rs1 = 5'd5;
    at_neg; chk("sw_busy_before", 32'(rs1_busy), 0);
    cyc(); issue_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    at_neg; chk("sw_busy_after_issue", 32'(rs1_busy), 1); chk("sw_ready", 32'(alu_ready), 1);
    cyc(); alu_valid = 1'b0;
    at_neg; chk("sw_we3", 32'(WE3), 1); chk("sw_a3", 32'(A3), 5);
    chk("sw_wd3", WD3, 32'hDEADBEEF); chk("sw_busy_write_cycle", 32'(rs1_busy), 1);
    cyc();
    at_neg; chk("sw_busy_cleared", 32'(rs1_busy), 0);

    // 3. conflict fairness after a fresh reset
    cyc(); RST = 1'b0;
    cyc(); RST = 1'b1;
    wlog.delete(); log_en = 1'b1; ai = 0; mi = 0; c = 0;
    while (c < 20 && (ai < 4 || mi < 4)) begin
      alu_valid = (ai < 4); alu_rd = 5'(1 + ai); alu_data = 32'(100 + ai);
      mem_valid = (mi < 4); mem_rd = 5'(9 + mi); mem_data = 32'(200 + mi);
      at_neg; ga = alu_ready; gm = mem_ready;
      cyc();
      if (ga) ai++;
      if (gm) mi++;
      c++;
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    at_neg; log_en = 1'b0;
    chk("fair_cycles", 32'(c), 8);
    chk("fair_writes", 32'(wlog.size()), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("fair_order%0d", i), (i < wlog.size()) ? 32'(wlog[i]) : 32'hFFFF, 32'(exp_seq[i]));

    // 4. x0 write
    cyc(); mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h1234;
    at_neg; chk("x0_mem_ready", 32'(mem_ready), 1);
    cyc(); mem_valid = 1'b0;
    at_neg; chk("x0_we3", 32'(WE3), 0);

    // 5. set and clear collide on x7
    cyc(); alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    at_neg;
    cyc(); alu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd7;
    at_neg; chk("col_we3", 32'(WE3), 1); chk("col_a3", 32'(A3), 7); chk("col_rd_busy_pre", 32'(rd_busy), 0);
    cyc(); issue_valid = 1'b0;
    at_neg; chk("col_set_wins", 32'(rd_busy), 1);
    cyc(); alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h78;
    at_neg;
    cyc(); alu_valid = 1'b0;
    at_neg;
    cyc();
    at_neg; chk("col_cleared", 32'(rd_busy), 0);

    // 6. reset with a write in flight
    cyc(); issue_valid = 1'b1; issue_rd = 5'd3; rs1 = 5'd3;
    cyc(); issue_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    at_neg; chk("mf_busy", 32'(rs1_busy), 1);
    cyc(); alu_valid = 1'b0;
    #1 chk("mf_we3_inflight", 32'(WE3), 1);
    #1 RST = 1'b0;
    #1 chk("mf_we3_dropped", 32'(WE3), 0);
    at_neg;
    cyc(); RST = 1'b1;
    at_neg; chk("mf_pend_cleared", 32'(rs1_busy), 0); chk("mf_we3_after", 32'(WE3), 0);
    cyc();
    at_neg;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
